reg_write_sequencer: RTL
========================

# reg_write_sequencer

Register-bus write initiator: accepts write commands from a host-side controller over a valid/ready handshake and drives the chip register bus (`address`, `wdata`, `xfc`) that the register-decode and trigger-generator blocks consume. Each command is a burst of one or more single-cycle write strobes to word-spaced addresses (+4 per beat). It sits between the host command path and all register/trigger decoders, and is the only driver of the register write bus.

## Interface
Parameters:
- `GAP`, default 0: idle cycles inserted between consecutive `xfc` strobes of one burst (0..15).
- `FIFO_DEPTH`, default 4: command FIFO entries, power of two; used only with `REG_WRITE_SEQUENCER_FIFO_EN`.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_addr`  in  12  start byte address; must be word-aligned, bits [1:0] ignored and forced to 0.
- `cmd_data`  in  8  data written on every beat of the burst.
- `cmd_len`  in  4  beats minus one (0 = 1 beat, 15 = 16 beats).
- `address`  out  12  register bus address, registered.
- `wdata`  out  8  register bus write data, registered.
- `xfc`  out  1  one-cycle write strobe, registered.
- `busy`  out  1  burst in progress or command pending.
- `done`  out  1  one-cycle pulse after the last beat of each command.

## Operation
- Handshake: command accepted on a rising edge where `cmd_valid && cmd_ready`. Host holds fields stable while `cmd_valid && !cmd_ready`. `cmd_ready = !full && !rst`.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if a command is pending, load working regs (`addr_q`, `data_q`, `beats_q = cmd_len`, `gap_q = GAP`) -> ISSUE.
  - ISSUE: `xfc`=1 for exactly this cycle, with `address = addr_q`, `wdata = data_q`. If `beats_q == 0` -> DONE. Else `addr_q += 4`, `beats_q -= 1`, then -> WAIT if `GAP > 0`, else stay in ISSUE.
  - WAIT: decrement `gap_q`; at 1 reload it and -> ISSUE.
  - DONE: `done`=1 for one cycle, then -> IDLE. Exactly one idle cycle always separates commands.
- Address arithmetic is modulo 4096: 0xFFC + 4 = 0x000. There is no error flag.
- `address` and `wdata` hold their last driven values while `xfc`=0.
- `busy` = (state != IDLE) || pending command.
- Reset mid-burst: the remaining beats and all queued commands are discarded, and `done` is not pulsed.

## Timing
- Reset values: `address`=0, `wdata`=0, `xfc`=0, `done`=0, `busy`=0, `cmd_ready`=0 while `rst`=1; `cmd_ready`=1 in the first cycle after reset.
- Latency: command accepted at edge E (sequencer idle, nothing queued). The working regs load at E+1 and `xfc` is high in the cycle after edge E+2.
- Burst of N beats: `xfc` high in N cycles spaced `GAP+1` apart. `done` is high in the cycle after the last strobe.
- Simultaneous accept and pop on a full FIFO is not allowed, because `cmd_ready`=0 when full. Accept and pop in the same edge with the FIFO non-full is legal, and occupancy is unchanged.

## Configuration
- `REG_WRITE_SEQUENCER_FIFO_EN` defined: a `FIFO_DEPTH`-entry command FIFO buffers commands.
  - `cmd_ready` stays high during bursts until the FIFO is full.
  - Back-to-back commands issue with only the DONE+IDLE gap between them.
- Undefined: a single holding register replaces the FIFO.
  - `cmd_ready`=1 only when the holding register is empty.
  - The holding register empties at the IDLE load, so one command can be accepted while the previous burst runs.
  - `FIFO_DEPTH` is ignored.

## Test plan
- Reset, then send a 1-beat command (addr 0x010, data 0xFF, len 0). Required: `xfc` high for 1 cycle, 2 edges after accept, with `address`=0x010 and `wdata`=0xFF; `done` pulses the next cycle; `busy` returns to 0.
- Burst from 0x000, len 7, GAP=0. Required: 8 consecutive `xfc` cycles at addresses 0x000, 0x004, …, 0x01C, all with the same data; exactly one `done`.
- Burst at 0xFF8, len 3, GAP=2. Required: strobes at 0xFF8, 0xFFC, 0x000, 0x004, each separated by 2 idle cycles.
- FIFO enabled, 5 commands offered back-to-back with `cmd_valid` held high. Required: `cmd_ready` drops once the FIFO is full; all 5 commands are issued in order; each command's `done` is followed by one idle cycle before its successor's first strobe.
- Assert `rst` during beat 3 of a 16-beat burst with 2 commands queued. Required: the next cycle has `xfc`=0, `address`=0, no `done`, `busy`=0, and nothing issues after reset is released.
- `cmd_addr`=0x013. Required: the first strobe is at 0x010.

Source files
------------

// File: rtl/reg_write_sequencer.sv
// reg_write_sequencer: register-bus write burst initiator.
// Takes host write commands (valid/ready) and drives address/wdata/xfc.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready handshake;
//   cmd_addr[11:0] start byte addr, cmd_data[7:0], cmd_len[3:0] beats-1;
//   address[11:0], wdata[7:0], xfc strobe; busy; done pulse per command.
// Params: GAP idle cycles between strobes; FIFO_DEPTH (power of two, >= 2).
// Macro REG_WRITE_SEQUENCER_FIFO_EN selects a command FIFO instead of
//   a single holding register.
module reg_write_sequencer #(
  parameter int GAP        = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic [3:0]  cmd_len,
  output logic [11:0] address,
  output logic [7:0]  wdata,
  output logic        xfc,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_n;
  logic [11:0] addr_q;
  logic [7:0]  data_q;
  logic [3:0]  beats_q;
  logic [3:0]  gap_q;

  logic        pend;
  logic        full;
  logic        push;
  logic        pop;
  logic [11:0] h_addr;
  logic [7:0]  h_data;
  logic [3:0]  h_len;

  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && pend;
  assign busy      = (state != IDLE) || pend;

`ifdef REG_WRITE_SEQUENCER_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [23:0] mem [FIFO_DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= {cmd_addr, cmd_data, cmd_len};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
    end
  end

  // Extra pointer bit distinguishes full from empty.
  assign pend = (wp != rp);
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign {h_addr, h_data, h_len} = mem[rp[AW-1:0]];
`else
  logic h_valid;

  // Push needs an empty register and pop a full one, so they never
  // coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid <= 1'b0;
      h_addr  <= '0;
      h_data  <= '0;
      h_len   <= '0;
    end else if (push) begin
      h_valid <= 1'b1;
      h_addr  <= cmd_addr;
      h_data  <= cmd_data;
      h_len   <= cmd_len;
    end else if (pop) begin
      h_valid <= 1'b0;
    end
  end

  assign pend = h_valid;
  assign full = h_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (pend) state_n = ISSUE;
      ISSUE: begin
        if (beats_q == 4'd0) state_n = DONE;
        else if (GAP > 0)    state_n = WAIT;
        else                 state_n = ISSUE;
      end
      WAIT:  if (gap_q <= 4'd1) state_n = ISSUE;
      DONE:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      beats_q <= '0;
      gap_q   <= '0;
      address <= '0;
      wdata   <= '0;
      xfc     <= 1'b0;
      done    <= 1'b0;
    end else begin
      // Strobe and done are registered, so each trails its state by a cycle.
      xfc  <= (state == ISSUE);
      done <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (pend) begin
            addr_q  <= h_addr & 12'hFFC;
            data_q  <= h_data;
            beats_q <= h_len;
            gap_q   <= 4'(GAP);
          end
        end
        ISSUE: begin
          address <= addr_q;
          wdata   <= data_q;
          if (beats_q != 4'd0) begin
            addr_q  <= addr_q + 12'd4;
            beats_q <= beats_q - 4'd1;
          end
        end
        WAIT: begin
          if (gap_q <= 4'd1) gap_q <= 4'(GAP);
          else               gap_q <= gap_q - 4'd1;
        end
        DONE: ;
      endcase
    end
  end

endmodule
